// File: rtl/access_game_pkg.sv
// Shared types, width helpers and code-digit selection for the access/game controller.
`timescale 1ns/1ps
package access_game_pkg;

    localparam int unsigned MAX_CODE_W  = 64;
    localparam int unsigned MAX_DIGIT_W = 16;

    typedef enum logic [3:0] {
        ENTRY    = 4'd0,
        CHECK    = 4'd1,
        LOCKOUT  = 4'd2,
        UNLOCKED = 4'd3,
        CONFIG   = 4'd4,
        ARMED    = 4'd5,
        RUN      = 4'd6,
        EVAL     = 4'd7,
        RETRY    = 4'd8,
        RECONF   = 4'd9,
        FAIL     = 4'd10
    } state_t;

    // Bits needed to hold 0..max_val, never less than one.
    function automatic int unsigned width_for(input int unsigned max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

    // Digit idx of a code; digit 0 sits in the most significant bits.
    function automatic logic [MAX_DIGIT_W-1:0] code_digit(
        input logic [MAX_CODE_W-1:0] code,
        input int unsigned           digit_w,
        input int unsigned           code_len,
        input int unsigned           idx
    );
        logic [MAX_CODE_W-1:0] mask;
        mask = (MAX_CODE_W'(1) << digit_w) - MAX_CODE_W'(1);
        return MAX_DIGIT_W'((code >> ((code_len - 1 - idx) * digit_w)) & mask);
    endfunction

endpackage

// File: rtl/access_game_ctrl_tick_down_counter.sv
// Loadable down-counter stepped by tick; done_c flags the tick that reaches zero.
`timescale 1ns/1ps
module tick_down_counter #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         tick,
    output logic         done_c
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d  = cnt_q;
        done_c = 1'b0;
        if (load) begin
            cnt_d = load_val;
        end else if (tick && (cnt_q != '0)) begin
            cnt_d  = cnt_q - W'(1);
            done_c = (cnt_q == W'(1));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end

endmodule

// File: rtl/access_game_ctrl.sv
// Passcode gate with timed lockout, followed by the game round sequencer.
`timescale 1ns/1ps
module access_game_ctrl
    import access_game_pkg::*;
#(
    parameter int unsigned                   DIGIT_W    = 4,
    parameter int unsigned                   CODE_LEN   = 4,
    parameter logic [CODE_LEN*DIGIT_W-1:0]   CODE_VALUE = 16'h9909,
    parameter int unsigned                   MAX_TRIES  = 3,
    parameter int unsigned                   LOCK_TICKS = 10,
    parameter int unsigned                   CNT_W      = 3,
    parameter int unsigned                   RECONF_MAX = 1
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               button_push,
    input  logic [DIGIT_W-1:0]                 digit_in,
    input  logic                               tick_1s,
    input  logic                               window_done,
    input  logic                               rng_button,
    input  logic                               load_in,
    output logic [DIGIT_W-1:0]                 digit_echo,
    output logic                               green_led,
    output logic                               red_led,
    output logic                               lock_led,
    output logic                               donot_borrow,
    output logic                               reconfig,
    output logic                               enable,
    output logic                               timer_enable,
    output logic                               load_out,
    output logic                               rng_out,
    output logic [width_for(MAX_TRIES)-1:0]    fail_count,
    output logic [CNT_W-1:0]                   push_count
);

    localparam int unsigned IDX_W  = width_for(CODE_LEN - 1);
    localparam int unsigned FAIL_W = width_for(MAX_TRIES);
    localparam int unsigned LOCK_W = width_for(LOCK_TICKS);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               match_q, match_d;
    logic [DIGIT_W-1:0] digit_echo_q, digit_echo_d;
    logic               green_q, green_d, red_q, red_d, lock_q, lock_d;
    logic               donot_q, donot_d, reconfig_q, reconfig_d;
    logic               enable_q, enable_d, timer_q, timer_d;
    logic               load_out_q, load_out_d, rng_out_q, rng_out_d;
    logic [FAIL_W-1:0]  fail_q, fail_d;
    logic [CNT_W-1:0]   push_cnt_q, push_cnt_d;
    logic               digit_ok_c, lock_load_c, lock_done_c;

    assign digit_ok_c = (digit_in == DIGIT_W'(code_digit(MAX_CODE_W'(CODE_VALUE), DIGIT_W,
                                                         CODE_LEN, 32'(idx_q))));

    tick_down_counter #(.W(LOCK_W)) u_lock_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (lock_load_c),
        .load_val (LOCK_W'(LOCK_TICKS)),
        .tick     (tick_1s && (state_q == LOCKOUT)),
        .done_c   (lock_done_c)
    );

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        match_d      = match_q;
        digit_echo_d = digit_echo_q;
        green_d      = green_q;
        red_d        = red_q;
        lock_d       = lock_q;
        donot_d      = donot_q;
        reconfig_d   = reconfig_q;
        enable_d     = enable_q;
        timer_d      = timer_q;
        load_out_d   = load_out_q;
        rng_out_d    = rng_out_q;
        fail_d       = fail_q;
        push_cnt_d   = push_cnt_q;
        lock_load_c  = 1'b0;

        case (state_q)
            ENTRY: begin
                red_d   = 1'b1;
                green_d = 1'b0;
                if (button_push) begin
                    digit_echo_d = digit_in;
                    // A fresh entry always starts from an assumed match.
                    match_d = ((idx_q == '0) ? 1'b1 : match_q) & digit_ok_c;
                    if (idx_q == IDX_W'(CODE_LEN - 1)) begin
                        idx_d   = '0;
                        state_d = CHECK;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            CHECK: begin
                match_d = 1'b1;
                if (match_q) begin
                    green_d = 1'b1;
                    red_d   = 1'b0;
                    donot_d = 1'b1;
                    fail_d  = '0;
                    state_d = UNLOCKED;
                end else if (fail_q == FAIL_W'(MAX_TRIES - 1)) begin
                    lock_d      = 1'b1;
                    lock_load_c = 1'b1;
                    state_d     = LOCKOUT;
                end else begin
                    fail_d  = fail_q + FAIL_W'(1);
                    state_d = ENTRY;
                end
            end
            LOCKOUT: begin
                if (lock_done_c) begin
                    lock_d  = 1'b0;
                    fail_d  = '0;
                    match_d = 1'b1;
                    state_d = ENTRY;
                end
            end
            UNLOCKED: begin
                if (button_push) begin
                    reconfig_d = 1'b1;
                    state_d    = CONFIG;
                end
            end
            CONFIG: begin
                reconfig_d = 1'b0;
                if (button_push) begin
                    enable_d = 1'b1;
                    state_d  = ARMED;
                end
            end
            ARMED: begin
                load_out_d = load_in;
                rng_out_d  = ~rng_button;
                push_cnt_d = '0;
                if (button_push) begin
                    timer_d = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (button_push && (push_cnt_q != CNT_MAX)) push_cnt_d = push_cnt_q + CNT_W'(1);
                if (window_done) state_d = EVAL;
            end
            EVAL: begin
                timer_d = 1'b0;
                if (push_cnt_q == '0)                    state_d = RETRY;
                else if (32'(push_cnt_q) <= RECONF_MAX)  state_d = RECONF;
                else                                     state_d = FAIL;
            end
            RETRY: begin
                enable_d = 1'b0;
                if (button_push) begin
                    enable_d = 1'b1;
                    state_d  = ARMED;
                end
            end
            RECONF: begin
                enable_d   = 1'b0;
                reconfig_d = 1'b1;
                if (button_push) begin
                    reconfig_d = 1'b0;
                    enable_d   = 1'b1;
                    state_d    = ARMED;
                end
            end
            FAIL: begin
                green_d    = 1'b0;
                red_d      = 1'b1;
                donot_d    = 1'b0;
                enable_d   = 1'b0;
                reconfig_d = 1'b0;
                timer_d    = 1'b0;
                state_d    = ENTRY;
            end
            default: begin
                state_d      = ENTRY;
                idx_d        = '0;
                match_d      = 1'b0;
                digit_echo_d = '0;
                green_d      = 1'b0;
                red_d        = 1'b0;
                lock_d       = 1'b0;
                donot_d      = 1'b0;
                reconfig_d   = 1'b0;
                enable_d     = 1'b0;
                timer_d      = 1'b0;
                load_out_d   = 1'b0;
                rng_out_d    = 1'b0;
                fail_d       = '0;
                push_cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= ENTRY;
            idx_q        <= '0;
            match_q      <= 1'b0;
            digit_echo_q <= '0;
            green_q      <= 1'b0;
            red_q        <= 1'b0;
            lock_q       <= 1'b0;
            donot_q      <= 1'b0;
            reconfig_q   <= 1'b0;
            enable_q     <= 1'b0;
            timer_q      <= 1'b0;
            load_out_q   <= 1'b0;
            rng_out_q    <= 1'b0;
            fail_q       <= '0;
            push_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            match_q      <= match_d;
            digit_echo_q <= digit_echo_d;
            green_q      <= green_d;
            red_q        <= red_d;
            lock_q       <= lock_d;
            donot_q      <= donot_d;
            reconfig_q   <= reconfig_d;
            enable_q     <= enable_d;
            timer_q      <= timer_d;
            load_out_q   <= load_out_d;
            rng_out_q    <= rng_out_d;
            fail_q       <= fail_d;
            push_cnt_q   <= push_cnt_d;
        end
    end

    assign digit_echo   = digit_echo_q;
    assign green_led    = green_q;
    assign red_led      = red_q;
    assign lock_led     = lock_q;
    assign donot_borrow = donot_q;
    assign reconfig     = reconfig_q;
    assign enable       = enable_q;
    assign timer_enable = timer_q;
    assign load_out     = load_out_q;
    assign rng_out      = rng_out_q;
    assign fail_count   = fail_q;
    assign push_count   = push_cnt_q;

endmodule

// File: tb/tb_access_game_ctrl.sv
// Directed bench: default-parameter controller plus a 6x3-bit code, 2-bit counter variant.
`timescale 1ns/1ps
module tb_access_game_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, tick, wdone, rng_btn, load_in;
    logic       btn_a, btn_b;
    logic [3:0] dig_a;
    logic [2:0] dig_b;

    logic [3:0] echo_a;
    logic       green_a, red_a, lock_a, donot_a, reconf_a, en_a, timer_a, lout_a, rout_a;
    logic [1:0] fail_a;
    logic [2:0] push_a;

    logic [2:0] echo_b;
    logic       green_b, red_b, lock_b, donot_b, reconf_b, en_b, timer_b, lout_b, rout_b;
    logic [1:0] fail_b;
    logic [1:0] push_b;

    int tests = 0;
    int fails = 0;

    access_game_ctrl dut_a (
        .clk(clk), .rst(rst), .button_push(btn_a), .digit_in(dig_a), .tick_1s(tick),
        .window_done(wdone), .rng_button(rng_btn), .load_in(load_in),
        .digit_echo(echo_a), .green_led(green_a), .red_led(red_a), .lock_led(lock_a),
        .donot_borrow(donot_a), .reconfig(reconf_a), .enable(en_a), .timer_enable(timer_a),
        .load_out(lout_a), .rng_out(rout_a), .fail_count(fail_a), .push_count(push_a)
    );

    access_game_ctrl #(
        .DIGIT_W(3), .CODE_LEN(6), .CODE_VALUE(18'o123456), .CNT_W(2)
    ) dut_b (
        .clk(clk), .rst(rst), .button_push(btn_b), .digit_in(dig_b), .tick_1s(tick),
        .window_done(wdone), .rng_button(rng_btn), .load_in(load_in),
        .digit_echo(echo_b), .green_led(green_b), .red_led(red_b), .lock_led(lock_b),
        .donot_borrow(donot_b), .reconfig(reconf_b), .enable(en_b), .timer_enable(timer_b),
        .load_out(lout_b), .rng_out(rout_b), .fail_count(fail_b), .push_count(push_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pa(input logic [3:0] d);
        dig_a = d; btn_a = 1'b1; cyc(1); btn_a = 1'b0;
    endtask

    task automatic pb(input logic [2:0] d);
        dig_b = d; btn_b = 1'b1; cyc(1); btn_b = 1'b0;
    endtask

    task automatic code_a(input logic [3:0] d0, input logic [3:0] d1,
                          input logic [3:0] d2, input logic [3:0] d3);
        pa(d0); pa(d1); pa(d2); pa(d3);
    endtask

    initial begin
        rst = 1'b0; tick = 1'b0; wdone = 1'b0; rng_btn = 1'b1; load_in = 1'b0;
        btn_a = 1'b0; btn_b = 1'b0; dig_a = 4'd0; dig_b = 3'd0;
        cyc(3);
        chk("reset_a", 32'({echo_a, green_a, red_a, lock_a, donot_a, reconf_a, en_a, timer_a,
                            lout_a, rout_a, fail_a, push_a}), 32'd0);
        chk("reset_b", 32'({echo_b, green_b, red_b, lock_b, donot_b, reconf_b, en_b, timer_b,
                            lout_b, rout_b, fail_b, push_b}), 32'd0);
        rst = 1'b1;
        cyc(1);
        chk("entry_red", 32'({red_a, green_a}), 32'b10);

        // correct code: result lands two edges after the last push
        code_a(4'd9, 4'd9, 4'd0, 4'd9);
        chk("check_cycle_green", 32'(green_a), 32'd0);
        cyc(1);
        chk("unlock_leds", 32'({green_a, red_a, donot_a}), 32'b101);
        chk("unlock_fail", 32'(fail_a), 32'd0);
        chk("unlock_echo", 32'(echo_a), 32'd9);

        pa(4'd0);
        chk("reconfig_pulse", 32'(reconf_a), 32'd1);
        cyc(1);
        chk("reconfig_drop", 32'(reconf_a), 32'd0);
        load_in = 1'b1; rng_btn = 1'b0;
        pa(4'd0);
        chk("armed_enable", 32'(en_a), 32'd1);
        cyc(1);
        chk("armed_sample", 32'({lout_a, rout_a}), 32'b11);
        pa(4'd0);
        chk("run_timer", 32'({timer_a, push_a}), 32'b1000);
        load_in = 1'b0; rng_btn = 1'b1;
        cyc(1);
        chk("run_hold_io", 32'({lout_a, rout_a}), 32'b11);

        // zero pushes -> RETRY
        wdone = 1'b1; cyc(1); wdone = 1'b0;
        cyc(1);
        chk("eval_timer_off", 32'({timer_a, en_a}), 32'b01);
        cyc(1);
        chk("retry_enable", 32'(en_a), 32'd0);

        // one push -> RECONF
        pa(4'd0);
        chk("retry_rearm", 32'(en_a), 32'd1);
        pa(4'd0);
        pa(4'd0);
        wdone = 1'b1; cyc(1); wdone = 1'b0;
        cyc(2);
        chk("reconf_state", 32'({reconf_a, en_a, push_a}), 32'b10001);
        pa(4'd0);
        chk("reconf_rearm", 32'({reconf_a, en_a}), 32'b01);
        cyc(1);
        chk("armed_clear_cnt", 32'(push_a), 32'd0);

        // two pushes, second coincident with window_done -> FAIL
        pa(4'd0);
        pa(4'd0);
        wdone = 1'b1; pa(4'd0); wdone = 1'b0;
        chk("same_cycle_push", 32'(push_a), 32'd2);
        cyc(2);
        chk("fail_outputs", 32'({green_a, red_a, donot_a, en_a, reconf_a, timer_a}), 32'b010000);
        cyc(1);
        chk("back_to_entry", 32'({green_a, red_a}), 32'b01);

        // wrong code then correct code
        code_a(4'd9, 4'd9, 4'd1, 4'd9);
        cyc(1);
        chk("wrong_fail_cnt", 32'({fail_a, green_a, red_a}), 32'b0101);
        code_a(4'd9, 4'd9, 4'd0, 4'd9);
        cyc(1);
        chk("retry_unlock", 32'({fail_a, green_a}), 32'b001);

        // reset in the middle of a round
        pa(4'd0); pa(4'd0); pa(4'd0);
        chk("pre_reset_run", 32'(timer_a), 32'd1);
        rst = 1'b0;
        cyc(1);
        chk("mid_round_reset", 32'({echo_a, green_a, red_a, lock_a, donot_a, reconf_a, en_a,
                                   timer_a, lout_a, rout_a, fail_a, push_a}), 32'd0);
        rst = 1'b1;
        cyc(1);

        // three wrong codes -> lockout
        code_a(4'd1, 4'd2, 4'd3, 4'd4); cyc(1);
        code_a(4'd9, 4'd9, 4'd0, 4'd8); cyc(1);
        chk("two_fails", 32'(fail_a), 32'd2);
        code_a(4'd0, 4'd0, 4'd0, 4'd9); cyc(1);
        chk("lockout_on", 32'({lock_a, fail_a}), 32'b110);
        pa(4'd5); pa(4'd5); pa(4'd5); pa(4'd5);
        cyc(2);
        chk("lockout_ignores_push", 32'({lock_a, green_a, echo_a}), 32'b1_0_1001);
        repeat (9) begin
            tick = 1'b1; cyc(1); tick = 1'b0; cyc(1);
        end
        chk("lockout_9_ticks", 32'(lock_a), 32'd1);
        tick = 1'b1; cyc(1); tick = 1'b0;
        chk("lockout_exit", 32'({lock_a, fail_a}), 32'b000);
        code_a(4'd9, 4'd9, 4'd0, 4'd9);
        cyc(1);
        chk("post_lock_unlock", 32'(green_a), 32'd1);

        // 6-digit 3-bit code and 2-bit push counter saturation
        pb(3'd1); pb(3'd2); pb(3'd3); pb(3'd4); pb(3'd5); pb(3'd6);
        cyc(1);
        chk("b_unlock", 32'({green_b, red_b, echo_b}), 32'b10_110);
        pb(3'd0);
        chk("b_reconfig", 32'(reconf_b), 32'd1);
        pb(3'd0); pb(3'd0);
        chk("b_run", 32'(timer_b), 32'd1);
        repeat (5) pb(3'd0);
        chk("b_saturate", 32'(push_b), 32'd3);
        wdone = 1'b1; cyc(1); wdone = 1'b0;
        cyc(2);
        chk("b_fail_round", 32'({green_b, red_b, en_b}), 32'b010);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
